// File: rtl/resource_arbiter.sv
// Round-robin arbiter that shares one fixed-latency resource among NUM_REQ requesters,
// with bounded hold under contention and an owner-tag pipeline that routes results back.
//
// state | meaning
// IDLE  | no grant; wait for any request
// OWN   | grant held by owner_q; hold_q counts consecutive granted cycles
`timescale 1ns/1ps
module resource_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int RES_LAT  = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         res_in,
  output logic                      res_in_valid,
  input  logic [DATA_W-1:0]         res_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e                      state_q, state_d;
  logic [IW-1:0]               owner_q, owner_d;
  logic [IW-1:0]               last_owner_q, last_owner_d;
  logic [HW-1:0]               hold_q, hold_d;
  logic [RES_LAT-1:0]          tag_v_q, tag_v_d;
  logic [RES_LAT-1:0][IW-1:0]  tag_idx_q, tag_idx_d;

  logic [NUM_REQ-1:0] pick_src;
  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0]      pick_base;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;

  assign grant        = (state_q == OWN) ? (NUM_REQ'(1) << owner_q) : '0;
  assign res_in_valid = (|(grant & req)) && !flush;
  assign rsp_valid    = tag_v_q[RES_LAT-1] ? (NUM_REQ'(1) << tag_idx_q[RES_LAT-1]) : '0;
  assign rsp_data     = res_out;
  assign busy         = |tag_v_q;

  always_comb begin
    res_in = '0;
    if (res_in_valid) res_in = req_data[int'(owner_q)*DATA_W +: DATA_W];
  end

  // Rotate candidates so bit 0 is the requester just after the search base; lowest set bit wins.
  always_comb begin
    pick_src   = (state_q == IDLE) ? req : (req & ~grant);
    pick_base  = (state_q == IDLE) ? last_owner_q : owner_q;
    rot        = NUM_REQ'({pick_src, pick_src} >> (int'(pick_base) + 1));
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(pick_base) + 1 + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    if (flush) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_d      = OWN;
            owner_d      = pick_idx;
            last_owner_d = pick_idx;
            hold_d       = '0;
          end
        end
        OWN: begin
          if (req[owner_q] && !(pick_found && hold_q >= HOLD_LAST)) begin
            if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
          end else if (pick_found) begin
            owner_d      = pick_idx;
            last_owner_d = pick_idx;
            hold_d       = '0;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tag_v_d      = '0;
    tag_idx_d    = tag_idx_q;
    tag_v_d[0]   = res_in_valid;
    tag_idx_d[0] = owner_q;
    for (int i = 1; i < RES_LAT; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    if (flush) tag_v_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      hold_q       <= '0;
      tag_v_q      <= '0;
      tag_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      tag_v_q      <= tag_v_d;
      tag_idx_q    <= tag_idx_d;
    end
  end

endmodule

// File: tb/tb_resource_arbiter.sv
// Directed bench for resource_arbiter: grant order, hold bound, issue mux, tag routing,
// flush and async reset, with a +1 resource model of latency 2.
`timescale 1ns/1ps
module tb_resource_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NT = 11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      grant;
  logic [DW-1:0]     res_in;
  logic              res_in_valid;
  logic [DW-1:0]     res_out;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  logic [DW-1:0]     p1 = '0;
  logic [DW-1:0]     p2 = '0;

  int checks = 0;
  int errors = 0;

  logic [3:0] one = 4'b0001;
  logic [3:0] exp_g;

  // Interleaved requesters 1 and 3: one row per cycle, inputs applied at the start of the cycle.
  logic [3:0]  t_req  [NT] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1010,
                               4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
  logic [31:0] t_d1   [NT] = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h20, 32'h20,
                               32'h20, 32'h50, 32'h50, 32'h50, 32'h50};
  logic [31:0] t_d3   [NT] = '{32'h30, 32'h30, 32'h30, 32'h30, 32'h30, 32'h40,
                               32'h40, 32'h40, 32'h40, 32'h40, 32'h40};
  logic [3:0]  t_gnt  [NT] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000,
                               4'b1000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
  logic        t_rsv  [NT] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] t_rin  [NT] = '{32'h0, 32'h10, 32'h20, 32'h0, 32'h30, 32'h40,
                               32'h0, 32'h50, 32'h0, 32'h0, 32'h0};
  logic [3:0]  t_rspv [NT] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                               4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
  logic [31:0] t_rspd [NT] = '{32'h0, 32'h0, 32'h0, 32'h11, 32'h21, 32'h0,
                               32'h31, 32'h41, 32'h0, 32'h51, 32'h0};

  resource_arbiter #(.NUM_REQ(N), .DATA_W(DW), .RES_LAT(2), .MAX_HOLD(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .res_in       (res_in),
    .res_in_valid (res_in_valid),
    .res_out      (res_out),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1 <= res_in + 32'd1;
    p2 <= p1;
  end
  assign res_out = p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    flush = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic [31:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_res_in_valid", 32'(res_in_valid), 32'h0);
    chk("rst_res_in", res_in, 32'h0);
    #1;
    reset = 1'b0;

    // single beat from requester 0
    req = 4'b0001;
    set_slot(0, 32'h11);
    #1;
    chk("t1_idle_grant", 32'(grant), 32'h0);
    chk("t1_idle_rsv", 32'(res_in_valid), 32'h0);
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_rsv", 32'(res_in_valid), 32'h1);
    chk("t1_res_in", res_in, 32'h11);
    chk("t1_rspv_c1", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_rspv_c2", 32'(rsp_valid), 32'h0);
    chk("t1_busy_c2", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    chk("t1_grant_c3", 32'(grant), 32'h0);
    chk("t1_rspv_c3", 32'(rsp_valid), 32'h1);
    chk("t1_rspd_c3", rsp_data, 32'h12);
    chk("t1_busy_c3", 32'(busy), 32'h1);
    tick();
    chk("t1_rspv_c4", 32'(rsp_valid), 32'h0);
    chk("t1_busy_c4", 32'(busy), 32'h0);

    // full contention: 0,1,2,3,0 each for 8 cycles
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_slot(i, 32'hA0 + 32'(i));
    tick();
    for (int k = 0; k < 33; k++) begin
      exp_g = one << ((k / 8) % 4);
      chk("rr_grant", 32'(grant), 32'(exp_g));
      chk("rr_res_in", res_in, 32'hA0 + 32'((k / 8) % 4));
      tick();
    end

    // owner 2 drops while 0 and 3 wait
    do_reset();
    req = 4'b0100;
    tick();
    chk("t3_grant2", 32'(grant), 32'h4);
    chk("t3_rsv", 32'(res_in_valid), 32'h1);
    req = 4'b1001;
    #1;
    chk("t3_drop_rsv", 32'(res_in_valid), 32'h0);
    chk("t3_drop_grant", 32'(grant), 32'h4);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("t3_hold3", 32'(grant), 32'h8);
      tick();
    end
    chk("t3_rotate0", 32'(grant), 32'h1);
    req = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t3_single_hold", 32'(grant), 32'h1);
    end

    // interleaved issue from requesters 1 and 3
    do_reset();
    for (int r = 0; r < NT; r++) begin
      req = t_req[r];
      set_slot(1, t_d1[r]);
      set_slot(3, t_d3[r]);
      #1;
      chk("t4_grant", 32'(grant), 32'(t_gnt[r]));
      chk("t4_rsv", 32'(res_in_valid), 32'(t_rsv[r]));
      chk("t4_res_in", res_in, t_rin[r]);
      chk("t4_rspv", 32'(rsp_valid), 32'(t_rspv[r]));
      if (t_rspv[r] != 4'b0000) chk("t4_rspd", rsp_data, t_rspd[r]);
      tick();
    end
    chk("t4_busy_end", 32'(busy), 32'h0);

    // flush with beats in flight, owner 1
    req = 4'b0010;
    set_slot(1, 32'hA0);
    #1;
    chk("t5_idle", 32'(grant), 32'h0);
    tick();
    chk("t5_grant1", 32'(grant), 32'h2);
    chk("t5_rsv1", 32'(res_in_valid), 32'h1);
    tick();
    flush = 1'b1;
    #1;
    chk("t5_flush_rsv", 32'(res_in_valid), 32'h0);
    chk("t5_flush_grant", 32'(grant), 32'h2);
    chk("t5_flush_busy", 32'(busy), 32'h1);
    tick();
    flush = 1'b0;
    chk("t5_post_grant", 32'(grant), 32'h0);
    chk("t5_post_rspv", 32'(rsp_valid), 32'h0);
    chk("t5_post_busy", 32'(busy), 32'h0);
    req = 4'b1111;
    tick();
    chk("t5_next_grant2", 32'(grant), 32'h4);
    chk("t5_next_rspv", 32'(rsp_valid), 32'h0);
    tick();
    tick();
    chk("t6_pre_rspv", 32'(rsp_valid), 32'h4);
    chk("t6_pre_busy", 32'(busy), 32'h1);

    // async reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_rspv", 32'(rsp_valid), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_rsv", 32'(res_in_valid), 32'h0);
    #1;
    reset = 1'b0;
    tick();
    chk("t6_after_grant0", 32'(grant), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
